// File: rtl/control_seq.sv
// control_seq: parametrised one-hot sequence controller with skip branch and pass counter; CONTROL_SEQ_ONEHOT_CHECK_EN adds a one-hot/index checker driving ERR
module control_seq #(
  parameter int NSTEPS = 6,
  parameter int SKIP_FROM = 2,
  parameter int SKIP_TO = 5,
  parameter int LOOPS = 0,
  parameter int CW = 8,
  localparam int SW = $clog2(NSTEPS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              OVERFLOW,
  input  logic              CLR,
  input  logic              HOLD,
  output logic [NSTEPS-1:0] S,
  output logic [SW-1:0]     STATE,
  output logic [CW-1:0]     PASS_CNT,
  output logic              DONE,
  output logic              ERR
);
  localparam logic [SW-1:0] LAST = SW'(NSTEPS - 1);
  localparam logic [SW-1:0] FROM = SW'(SKIP_FROM);
  localparam logic [SW-1:0] TO = SW'(SKIP_TO);
  localparam logic [CW:0] LIM = (CW+1)'(LOOPS);
  logic [SW-1:0] state_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [CW:0] pass_inc;
  logic done_nxt, again, bad;
  assign pass_inc = {1'b0, PASS_CNT} + (CW+1)'(1);
  assign again = LOOPS == 0 || pass_inc < LIM;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      S <= NSTEPS'(1);
      STATE <= '0;
      PASS_CNT <= '0;
      DONE <= 1'b0;
    end else if (bad) begin
      S <= NSTEPS'(1);
      STATE <= '0;
      DONE <= 1'b0;
    end else if (HOLD) begin
      DONE <= 1'b0;
    end else begin
      S <= NSTEPS'(1) << state_nxt;
      STATE <= state_nxt;
      PASS_CNT <= cnt_nxt;
      DONE <= done_nxt;
    end
  end
  always_comb begin
    state_nxt = STATE == '0 ? (OVERFLOW ? SW'(1) : '0)
              : STATE == FROM && CLR ? TO
              : STATE == LAST ? (again ? SW'(1) : '0)
              : STATE + SW'(1);
  end
  always_comb begin
    cnt_nxt = STATE == '0 ? (OVERFLOW ? '0 : PASS_CNT)
            : STATE == LAST ? (again ? pass_inc[CW-1:0] : LIM[CW-1:0])
            : PASS_CNT;
    done_nxt = STATE == LAST && !again;
  end
`ifdef CONTROL_SEQ_ONEHOT_CHECK_EN
  assign bad = S != (NSTEPS'(1) << STATE);
  always_ff @(posedge CLK) begin
    ERR <= RESET ? 1'b0 : ERR | bad;
  end
`else
  assign bad = 1'b0;
  assign ERR = 1'b0;
`endif
endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: directed bench for control_seq checked against a rule-level reference model
module tb_control_seq;
  logic clk = 0, rst = 1, ov = 0, clr = 0, hold = 0;
  logic [5:0] s0;
  logic [2:0] st0;
  logic [7:0] pc0;
  logic dn0, er0;
  logic [7:0] s1;
  logic [2:0] st1;
  logic [7:0] pc1;
  logic dn1, er1;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_st[2], m_cnt[2], m_done[2], m_err[2];
  control_seq dut0 (.CLK(clk), .RESET(rst), .OVERFLOW(ov), .CLR(clr), .HOLD(hold),
    .S(s0), .STATE(st0), .PASS_CNT(pc0), .DONE(dn0), .ERR(er0));
  control_seq #(.NSTEPS(8), .LOOPS(3)) dut1 (.CLK(clk), .RESET(rst), .OVERFLOW(ov), .CLR(clr), .HOLD(hold),
    .S(s1), .STATE(st1), .PASS_CNT(pc1), .DONE(dn1), .ERR(er1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int ns, lp;
      ns = i == 0 ? 6 : 8;
      lp = i == 0 ? 0 : 3;
      if (rst) begin
        m_st[i] = 0; m_cnt[i] = 0; m_done[i] = 0; m_err[i] = 0;
      end else begin
        m_done[i] = 0;
        if (!hold) begin
          if (m_st[i] == 0) begin
            if (ov) begin m_st[i] = 1; m_cnt[i] = 0; end
          end else if (m_st[i] == 2 && clr) m_st[i] = 5;
          else if (m_st[i] < ns - 1) m_st[i] = m_st[i] + 1;
          else if (lp == 0 || m_cnt[i] + 1 < lp) begin
            m_st[i] = 1; m_cnt[i] = (m_cnt[i] + 1) % 256;
          end else begin
            m_st[i] = 0; m_cnt[i] = lp; m_done[i] = 1;
          end
        end
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s0", s0, 1 << m_st[0]);
      chk("state0", st0, m_st[0]);
      chk("pass_cnt0", pc0, m_cnt[0]);
      chk("done0", dn0, m_done[0]);
      chk("err0", er0, m_err[0]);
      chk("s1", s1, 1 << m_st[1]);
      chk("state1", st1, m_st[1]);
      chk("pass_cnt1", pc1, m_cnt[1]);
      chk("done1", dn1, m_done[1]);
      chk("err1", er1, m_err[1]);
    end
  end
  task automatic wait_st(input int k);
    int n;
    n = 0;
    while (st0 != 3'(k) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_state%0d", k), st0, k);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int seq[$];
    int exp_a[12];
    int hc;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_s0", s0, 1);
    chk("rst_state0", st0, 0);
    chk("rst_pc0", pc0, 0);
    chk("rst_done0", dn0, 0);
    chk("rst_s1", s1, 1);
    rst = 0;
    ov = 1;
    @(negedge clk);
    ov = 0;
    seq.push_back(int'(st0));
    repeat (11) begin
      @(negedge clk);
      seq.push_back(int'(st0));
    end
    exp_a = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    foreach (exp_a[i]) chk($sformatf("seq_noskip%0d", i), seq[i], exp_a[i]);
    wait_st(2);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("skip_to5", st0, 5);
    @(negedge clk);
    chk("skip_wrap1", st0, 1);
    wait_st(3);
    clr = 1;
    @(negedge clk);
    clr = 0;
    chk("clr_s3_noeffect", st0, 4);
    wait_st(3);
    hold = 1;
    hc = m_cnt[0];
    repeat (4) begin
      @(negedge clk);
      chk("hold_state", st0, 3);
      chk("hold_s", s0, 6'b001000);
      chk("hold_pc", pc0, hc);
    end
    hold = 0;
    @(negedge clk);
    chk("hold_resume", st0, 4);
    rst = 1;
    hold = 1;
    @(negedge clk);
    chk("rst_hold_s", s0, 1);
    chk("rst_hold_pc", pc0, 0);
    chk("rst_hold_done", dn0, 0);
    rst = 0;
    hold = 0;
    ov = 1;
    @(negedge clk);
    ov = 0;
    chk("loop_start", st1, 1);
    repeat (21) @(negedge clk);
    chk("loop_done", dn1, 1);
    chk("loop_pc", pc1, 3);
    chk("loop_idle_s", s1, 1);
    @(negedge clk);
    chk("done_once", dn1, 0);
    chk("idle_pc", pc1, 3);
    chk("idle_stay", s1, 1);
    ov = 1;
    @(negedge clk);
    ov = 0;
    chk("restart_pc", pc1, 0);
    chk("restart_state", st1, 1);
    repeat (21) @(negedge clk);
    chk("run2_done", dn1, 1);
    ov = 1;
    @(negedge clk);
    ov = 0;
    chk("b2b_state", st1, 1);
    chk("b2b_pc", pc1, 0);
    chk("b2b_done", dn1, 0);
`ifdef CONTROL_SEQ_ONEHOT_CHECK_EN
    wait_st(1);
    chk_en = 0;
    @(posedge clk);
    #1 force dut0.S = 6'b000110;
    #1 release dut0.S;
    @(negedge clk);
    chk("inj_s", s0, 1);
    chk("inj_state", st0, 0);
    chk("inj_err", er0, 1);
    m_st[0] = 0;
    m_done[0] = 0;
    m_err[0] = 1;
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("err_sticky", er0, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("err_clear", er0, 0);
`endif
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/control_seq.md
# control_seq

Parametrised one-hot sequence controller, the next generation of the fixed six-state datapath control FSM. It waits in an idle state for a start condition (`OVERFLOW`), then steps through a configurable chain of one-hot work states. One configurable branch point can skip ahead when `CLR` is high. A programmable pass counter either loops forever or returns to idle with a `DONE` pulse after N passes. It sits between the datapath status flags and the per-step datapath enables.

## Interface
- `NSTEPS`, 6 — total states including idle `S[0]`; legal range 4..32
- `SKIP_FROM`, 2 — state index at which `CLR` is evaluated; 1 ≤ SKIP_FROM < SKIP_TO − 1
- `SKIP_TO`, 5 — state entered from `SKIP_FROM` when `CLR`=1; SKIP_TO ≤ NSTEPS−1
- `LOOPS`, 0 — passes per start; 0 = loop forever (never returns to idle except by reset)
- `CW`, 8 — pass counter width; LOOPS < 2^CW

Ports:
- `CLK` in 1 — clock, all state changes on the rising edge
- `RESET` in 1 — synchronous, active-high; highest priority
- `OVERFLOW` in 1 — start request, sampled only in `S[0]`
- `CLR` in 1 — skip select, sampled only in `S[SKIP_FROM]`
- `HOLD` in 1 — freeze: state, pass counter and outputs hold their values
- `S` out NSTEPS — registered one-hot state vector; `S[k]`=1 means in state k
- `STATE` out $clog2(NSTEPS) — registered binary index of the current state
- `PASS_CNT` out CW — completed passes since the last start
- `DONE` out 1 — one-cycle pulse on return to idle
- `ERR` out 1 — sticky illegal-state flag (see Configuration)

## Operation
- Reset (`RESET`=1 at an edge): `S`=1 (only `S[0]`), `STATE`=0, `PASS_CNT`=0, `DONE`=0, `ERR`=0. Applies regardless of `HOLD` or the current state, including mid-pass.
- Priority at each edge: RESET > HOLD > normal transition.
- `HOLD`=1: all registers keep their values, `DONE` forced 0. `OVERFLOW` and `CLR` are ignored that cycle.
- Transitions (no RESET, no HOLD):
  - `S[0]`: if `OVERFLOW`=1 go to `S[1]` and clear `PASS_CNT`; otherwise stay in `S[0]`.
  - `S[k]`, 1 ≤ k < NSTEPS−1: go to `S[k+1]`. Exception at k=SKIP_FROM with `CLR`=1: go to `S[SKIP_TO]`.
  - `S[NSTEPS−1]` (end of pass):
    - if LOOPS=0, go to `S[1]`; `PASS_CNT` increments and wraps modulo 2^CW.
    - if `PASS_CNT`+1 < LOOPS, go to `S[1]` and increment `PASS_CNT`.
    - otherwise go to `S[0]`, pulse `DONE`, and `PASS_CNT` takes the value LOOPS.
- With default parameters and LOOPS=0, the block is cycle-exact with the six-state controller: idle → 1 → 2 → (CLR ? 5 : 3 → 4 → 5) → 1 …
- `STATE` always encodes the same state as `S`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Start latency: `OVERFLOW` high at edge t while in `S[0]` gives `S[1]`=1 after edge t.
- One state per cycle. Pass length is NSTEPS−1 cycles, or NSTEPS−1−(SKIP_TO−SKIP_FROM−1) cycles when skipping.
- `DONE` is high for exactly the one cycle after the edge that enters `S[0]`. It does not re-pulse while idle.
- `OVERFLOW` arriving in the same cycle as `DONE` starts the next run on the following edge, with no extra idle cycle required.
- `CLR` outside `S[SKIP_FROM]` has no effect. `OVERFLOW` outside `S[0]` has no effect.

## Configuration
- `CONTROL_SEQ_ONEHOT_CHECK_EN` defined: each cycle the block checks that `S` is one-hot and that `STATE` matches it. On a mismatch, the next edge forces `S[0]` and `STATE`=0, and sets `ERR`. `ERR` stays high until `RESET`.
- Not defined: no checker is built and `ERR` is tied to 0.

## Test plan
- Defaults, LOOPS=0: reset, then `OVERFLOW` pulse, `CLR`=0 → `STATE` sequence 0,1,2,3,4,5,1,2,3,4,5,1…; `DONE` never asserts.
- Defaults, `CLR`=1 in `S[2]` → sequence 1,2,5,1; `CLR`=1 in `S[3]` has no effect.
- LOOPS=3, NSTEPS=8 → 3 passes of 7 cycles each, then `S[0]`, `DONE`=1 for one cycle, `PASS_CNT`=3. A fresh `OVERFLOW` clears `PASS_CNT` to 0.
- `HOLD`=1 for 4 cycles in `S[3]` → `S`, `STATE` and `PASS_CNT` unchanged; the sequence resumes at `S[4]`.
- `RESET` asserted in `S[4]` with `HOLD`=1 → next edge `S`=1, `PASS_CNT`=0, `DONE`=0.
- With the macro defined, force `S`=0b000110 → next edge `S`=1 and `ERR`=1; `ERR` holds until `RESET`.
